// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiply/divide unit: operation codes,
// control states and the architectural word width.
package mips_pkg;
    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the MIPS datapath (master) and the multiply/divide unit (slave).
interface muldiv_unit_if;
    import mips_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] DataA;
    logic [XLEN-1:0] DataB;
    logic            hi_we;
    logic            lo_we;
    logic [XLEN-1:0] wdata;
    logic            rd_req;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic            busy;
    logic            done;
    logic            hazard_hz;

    modport master (
        output start, op, DataA, DataB, hi_we, lo_we, wdata, rd_req,
        input  hi, lo, busy, done, hazard_hz
    );

    modport slave (
        input  start, op, DataA, DataB, hi_we, lo_we, wdata, rd_req,
        output hi, lo, busy, done, hazard_hz
    );
endinterface

// File: rtl/muldiv_datapath.sv
// Shift-add multiply / restoring divide on operand magnitudes, with the
// final sign correction applied combinationally to the accumulator.
module muldiv_datapath #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic            is_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_wide(input logic [2*XLEN-1:0] v);
        return ~v + 1'b1;
    endfunction

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   m;
    logic              div_r;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
        div_shift = acc[2*XLEN-1:XLEN-1];
        div_ge    = div_shift >= {1'b0, m};
        div_diff  = div_shift[XLEN-1:0] - m;
        if (div_r) begin
            acc_next = {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ge};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
    end

    // Divide-by-zero leaves the all-ones quotient untouched; the remainder
    // still regains the dividend's sign, which reproduces DataA exactly.
    always_comb begin
        prod   = neg_q ? neg_wide(acc) : acc;
        quo    = (neg_q && !div_zero) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
        rem    = neg_r ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
        res_hi = div_r ? rem : prod[2*XLEN-1:XLEN];
        res_lo = div_r ? quo : prod[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (load) begin
            acc      <= {{XLEN{1'b0}}, (is_div ? mag(a, is_signed) : mag(b, is_signed))};
            m        <= is_div ? mag(b, is_signed) : mag(a, is_signed);
            div_r    <= is_div;
            neg_q    <= is_signed & (a[XLEN-1] ^ b[XLEN-1]);
            neg_r    <= is_signed & a[XLEN-1];
            div_zero <= (b == '0);
        end else if (step) begin
            acc <= acc_next;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers and the hazard_hz stall line.
// Signed correction for MULT/DIV is built only when MULDIV_SIGNED_EN is defined.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    import mips_pkg::*;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    md_state_e        state_q;
    md_state_e        state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  hi_q;
    logic [XLEN-1:0]  lo_q;
    logic [XLEN-1:0]  res_hi;
    logic [XLEN-1:0]  res_lo;
    logic             done_q;
    logic             load;
    logic             step;
    logic             is_div;
    logic             is_signed;
    logic             busy;
    md_op_e           op_in;

    assign op_in  = md_op_e'(bus.op);
    assign is_div = (op_in == MD_DIVU) || (op_in == MD_DIV);
`ifdef MULDIV_SIGNED_EN
    assign is_signed = (op_in == MD_MULT) || (op_in == MD_DIV);
`else
    assign is_signed = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt_q == LAST) state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // MTHI/MTLO land only in IDLE; a same-cycle start is overwritten later by FIX
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FIX);
            cnt_q   <= step ? cnt_q + CNT_W'(1) : '0;
            if (state_q == FIX) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else if (state_q == IDLE) begin
                if (bus.hi_we) hi_q <= bus.wdata;
                if (bus.lo_we) lo_q <= bus.wdata;
            end
        end
    end

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk       (clk),
        .load      (load),
        .step      (step),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (bus.DataA),
        .b         (bus.DataB),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    assign busy          = (state_q != IDLE);
    assign bus.busy      = busy;
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.hazard_hz = busy & (bus.start | bus.rd_req | bus.hi_we | bus.lo_we);
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// operations against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    muldiv_unit_if bus();

    muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference result {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic        sgn;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
        sgn = op[0];
`else
        sgn = 1'b0;
`endif
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[1]) begin
            if (sgn) p = 64'(sa * sb);
            else     p = {32'd0, a} * {32'd0, b};
            return p;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    task automatic clear_inputs();
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.DataA  = '0;
        bus.DataB  = '0;
        bus.hi_we  = 1'b0;
        bus.lo_we  = 1'b0;
        bus.wdata  = '0;
        bus.rd_req = 1'b0;
    endtask

    // Issues one op at the current negedge and checks busy window, done pulse and result.
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        int busy_cycles = 0;
        int done_early  = 0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.DataA = a;
        bus.DataB = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            if (i > 1) @(negedge clk);
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done !== 1'b0) done_early++;
        end
        @(negedge clk);
        checks++;
        if (busy_cycles != 33) begin
            errors++;
            $display("FAIL %s busy_len: got %0d cycles, want 33", name, busy_cycles);
        end
        checks++;
        if (done_early != 0) begin
            errors++;
            $display("FAIL %s done_early: got %0d early pulses, want 0", name, done_early);
        end
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_T34: got done=%b busy=%b, want done=1 busy=0", name, bus.done, bus.busy);
        end
        checks++;
        if ({bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL %s result: got hi=%h lo=%h, want hi=%h lo=%h", name, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        bus.rd_req = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.hi, bus.lo} !== 64'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.hazard_hz !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got hi=%h lo=%h busy=%b done=%b hz=%b, want all zero",
                     bus.hi, bus.lo, bus.busy, bus.done, bus.hazard_hz);
        end
        bus.rd_req = 1'b0;
    endtask

    task automatic test_directed();
        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
`ifdef MULDIV_SIGNED_EN
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
`else
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFD, 32'd7, {32'h0000_0006, 32'hFFFF_FFEB});
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, {32'h0000_0001, 32'h7FFF_FFFC});
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000});
`endif
        run_op("divu_zero", MD_DIVU, 32'd100, 32'd0, {32'd100, 32'hFFFF_FFFF});
        run_op("div_zero_neg", MD_DIV, 32'hFFFF_FF00, 32'd0, ref_result(MD_DIV, 32'hFFFF_FF00, 32'd0));
        run_op("div_pos_neg", MD_DIV, 32'd7, 32'hFFFF_FFFE, ref_result(MD_DIV, 32'd7, 32'hFFFF_FFFE));
    endtask

    task automatic test_mtmf();
        bus.hi_we = 1'b1;
        bus.wdata = 32'hA5A5_0001;
        @(posedge clk);
        @(negedge clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b1;
        bus.wdata = 32'h5A5A_0002;
        @(posedge clk);
        @(negedge clk);
        bus.lo_we  = 1'b0;
        bus.rd_req = 1'b1;
        #1;
        checks++;
        if (bus.hi !== 32'hA5A5_0001 || bus.lo !== 32'h5A5A_0002) begin
            errors++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h, want hi=a5a50001 lo=5a5a0002", bus.hi, bus.lo);
        end
        checks++;
        if (bus.hazard_hz !== 1'b0) begin
            errors++;
            $display("FAIL idle_hazard: got hz=%b, want 0", bus.hazard_hz);
        end
        bus.rd_req = 1'b0;
        // MTHI together with start: write lands first, result overwrites it
        bus.hi_we = 1'b1;
        bus.wdata = 32'hCAFE_0003;
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.DataA = 32'd5;
        bus.DataB = 32'd6;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        checks++;
        if (bus.hi !== 32'hCAFE_0003) begin
            errors++;
            $display("FAIL mthi_with_start: got hi=%h, want cafe0003", bus.hi);
        end
        repeat (33) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== 64'd30) begin
            errors++;
            $display("FAIL start_overwrite: got done=%b hi=%h lo=%h, want done=1 hi=0 lo=1e", bus.done, bus.hi, bus.lo);
        end
    endtask

    task automatic test_stall();
        logic [63:0] exp;
        logic [31:0] hi_before;
        int          haz_bad = 0;
        exp = ref_result(MD_MULTU, 32'd123456, 32'd789);
        hi_before = bus.hi;
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.DataA = 32'd123456;
        bus.DataB = 32'd789;
        @(posedge clk);
        @(negedge clk);
        for (int i = 1; i <= 33; i++) begin
            if (i > 1) @(negedge clk);
            clear_inputs();
            if (i <= 20) begin
                case (i % 4)
                    0: bus.rd_req = 1'b1;
                    1: begin bus.hi_we = 1'b1; bus.wdata = 32'h1234; end
                    2: begin bus.start = 1'b1; bus.op = MD_DIVU; bus.DataA = 32'd99; bus.DataB = 32'd3; end
                    default: begin
                        bus.rd_req = 1'b1; bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'h1234;
                        bus.start = 1'b1; bus.op = MD_DIVU; bus.DataA = 32'd99; bus.DataB = 32'd3;
                    end
                endcase
                #1;
                if (bus.hazard_hz !== 1'b1) haz_bad++;
            end else if (i == 21) begin
                #1;
                checks++;
                if (bus.hazard_hz !== 1'b0 || bus.hi !== hi_before) begin
                    errors++;
                    $display("FAIL busy_quiet: got hz=%b hi=%h, want hz=0 hi=%h", bus.hazard_hz, bus.hi, hi_before);
                end
            end
        end
        checks++;
        if (haz_bad != 0) begin
            errors++;
            $display("FAIL stall_hazard: got %0d cycles without hz, want 0", haz_bad);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || {bus.hi, bus.lo} !== exp) begin
            errors++;
            $display("FAIL stall_result: got done=%b hi=%h lo=%h, want done=1 hi=%h lo=%h",
                     bus.done, bus.hi, bus.lo, exp[63:32], exp[31:0]);
        end
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL second_start: got busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_random();
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        for (int n = 0; n < 12; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 20));
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = 32'h8000_0000;
            run_op($sformatf("rand%0d", n), op, a, b, ref_result(op, a, b));
        end
    endtask

    task automatic test_reset_mid();
        int done_seen = 0;
        bus.start = 1'b1;
        bus.op    = MD_DIVU;
        bus.DataA = 32'd5000;
        bus.DataB = 32'd9;
        @(posedge clk);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            clear_inputs();
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b hi=%h lo=%h done=%b, want all zero",
                     bus.busy, bus.hi, bus.lo, bus.done);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL reset_no_done: got %0d active cycles, want 0", done_seen);
        end
        run_op("after_reset", MD_DIVU, 32'd1000, 32'd7, {32'd6, 32'd142});
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_directed();
        test_mtmf();
        test_stall();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
